// File: rtl/rgb_fade_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_fade_sequencer
//
// Drives the 8-bit duty cycles of the red, green and blue PWM generators.
// A start strobe latches a target colour, a mode and a step size. The
// sequencer then does one of three things:
//   direct  : jump to the target immediately
//   fade    : walk each channel linearly toward its target, one step per tick
//   breathe : ramp a shared envelope 0..255..0 forever and scale the target by it
// A prescaler turns the system clock into ticks, one every fade_div+1 cycles.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   ena              global enable; 0 freezes every register and drops strobes
//   start            one-cycle strobe: latch target_rgb/mode/step, begin sequence
//   stop             one-cycle strobe: end a fade or breathe sequence
//   target_rgb[23:0] {red, green, blue} target colour
//   mode[1:0]        00 direct, 01 fade, 10 breathe, 11 direct
//   step[3:0]        increment per tick (0 behaves as 1)
//   fade_div         tick period minus one, in clock cycles
//   duty_red/green/blue  registered duty cycles
//   busy             high while fading or breathing
//   done             one-cycle pulse when a sequence ends
// ---------------------------------------------------------------------------
module rgb_fade_sequencer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic [23:0]      target_rgb,
    input  logic [1:0]       mode,
    input  logic [3:0]       step,
    input  logic [DIV_W-1:0] fade_div,
    output logic [7:0]       duty_red,
    output logic [7:0]       duty_green,
    output logic [7:0]       duty_blue,
    output logic             busy,
    output logic             done
);

    // The latched mode is carried by the state itself: direct starts never
    // leave IDLE, so FADE and BREATHE are the only modes that persist.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FADE    = 2'd1,
        ST_BREATHE = 2'd2
    } state_t;

    state_t           r_state;
    logic [23:0]      r_tgt;
    logic [3:0]       r_step;
    logic [7:0]       r_lvl;
    logic             r_dir;
    logic [DIV_W-1:0] r_pc;
    logic [23:0]      r_duty;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [23:0]      w_tgt_nxt;
    logic [3:0]       w_step_nxt;
    logic [7:0]       w_lvl_nxt;
    logic             w_dir_nxt;
    logic [DIV_W-1:0] w_pc_nxt;
    logic [23:0]      w_duty_nxt;
    logic             w_done_nxt;

    logic             w_tick;
    logic [8:0]       w_lvl_sum;
    logic [23:0]      w_fade_duty;
    logic [23:0]      w_breathe_duty;

    // Move one channel toward its target by at most stp, never overshooting.
    function automatic logic [7:0] fade_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt,
                                               input logic [3:0] stp);
        logic [7:0] diff;
        logic [7:0] stp8;
        stp8 = {4'b0000, stp};
        if (cur < tgt) begin
            diff = tgt - cur;
            return cur + ((diff < stp8) ? diff : stp8);
        end else begin
            diff = cur - tgt;
            return cur - ((diff < stp8) ? diff : stp8);
        end
    endfunction

    // tgt * (lvl + 1) / 256: lvl = 255 reproduces tgt exactly, lvl = 0 gives 0.
    function automatic logic [7:0] scale(input logic [7:0] tgt,
                                         input logic [7:0] lvl);
        logic [15:0] prod;
        prod = {8'h00, tgt} * ({8'h00, lvl} + 16'd1);
        return prod[15:8];
    endfunction

    assign w_tick    = (r_state != ST_IDLE) && (r_pc == fade_div);
    assign w_lvl_sum = {1'b0, r_lvl} + {5'b00000, r_step};

    assign w_fade_duty = {fade_toward(r_duty[23:16], r_tgt[23:16], r_step),
                          fade_toward(r_duty[15:8],  r_tgt[15:8],  r_step),
                          fade_toward(r_duty[7:0],   r_tgt[7:0],   r_step)};

    // Duties trail the envelope by one cycle: they are scaled from the
    // registered lvl, not from the value being computed this cycle.
    assign w_breathe_duty = {scale(r_tgt[23:16], r_lvl),
                             scale(r_tgt[15:8],  r_lvl),
                             scale(r_tgt[7:0],   r_lvl)};

    // NOTE: every variable gets its hold value before any branch, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_step_nxt  = r_step;
        w_lvl_nxt   = r_lvl;
        w_dir_nxt   = r_dir;
        w_pc_nxt    = r_pc;
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;

        if (ena) begin
            if (start) begin
                // start beats stop and any pending tick in the same cycle
                w_tgt_nxt  = target_rgb;
                w_step_nxt = (step == 4'd0) ? 4'd1 : step;
                w_pc_nxt   = '0;
                case (mode)
                    2'b01: w_state_nxt = ST_FADE;
                    2'b10: begin
                        w_state_nxt = ST_BREATHE;
                        w_lvl_nxt   = 8'd0;
                        w_dir_nxt   = 1'b1;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_duty_nxt  = target_rgb;
                        w_done_nxt  = 1'b1;
                    end
                endcase
            end else if (stop && (r_state != ST_IDLE)) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end else if (r_state != ST_IDLE) begin
                w_pc_nxt = w_tick ? '0 : r_pc + 1'b1;

                if (r_state == ST_FADE && w_tick) begin
                    w_duty_nxt = w_fade_duty;
                    if (w_fade_duty == r_tgt) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end

                if (r_state == ST_BREATHE) begin
                    w_duty_nxt = w_breathe_duty;
                    if (w_tick) begin
                        if (r_dir) begin
                            if (w_lvl_sum >= 9'd255) begin
                                w_lvl_nxt = 8'd255;
                                w_dir_nxt = 1'b0;
                            end else begin
                                w_lvl_nxt = w_lvl_sum[7:0];
                            end
                        end else begin
                            if ({4'b0000, r_step} >= r_lvl) begin
                                w_lvl_nxt = 8'd0;
                                w_dir_nxt = 1'b1;
                            end else begin
                                w_lvl_nxt = r_lvl - {4'b0000, r_step};
                            end
                        end
                    end
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values computed above from the same pre-edge state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_tgt   <= 24'h000000;
            r_step  <= 4'd1;
            r_lvl   <= 8'd0;
            r_dir   <= 1'b1;
            r_pc    <= '0;
            r_duty  <= 24'h000000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_step  <= w_step_nxt;
            r_lvl   <= w_lvl_nxt;
            r_dir   <= w_dir_nxt;
            r_pc    <= w_pc_nxt;
            r_duty  <= w_duty_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign duty_red   = r_duty[23:16];
    assign duty_green = r_duty[15:8];
    assign duty_blue  = r_duty[7:0];
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rgb_fade_sequencer
//
// Self-checking bench for rgb_fade_sequencer. A behavioural model built from
// integer arithmetic tracks the expected duties, busy and done; a compare
// process checks the DUT against it on every falling edge. Directed scenarios
// pin the model with hand-computed values, then a long randomized run follows.
// ---------------------------------------------------------------------------
module tb_rgb_fade_sequencer;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             ena;
    logic             start;
    logic             stop;
    logic [23:0]      target_rgb;
    logic [1:0]       mode;
    logic [3:0]       step;
    logic [DIV_W-1:0] fade_div;
    logic [7:0]       duty_red;
    logic [7:0]       duty_green;
    logic [7:0]       duty_blue;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    rgb_fade_sequencer #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .start      (start),
        .stop       (stop),
        .target_rgb (target_rgb),
        .mode       (mode),
        .step       (step),
        .fade_div   (fade_div),
        .duty_red   (duty_red),
        .duty_green (duty_green),
        .duty_blue  (duty_blue),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // activity: 0 = idle, 1 = fading, 2 = breathing
    int m_activity;
    int m_duty[3];
    int m_tgt[3];
    int m_lvl;
    int m_rising;
    int m_pc;
    int m_stp;
    int m_done;
    int m_tick;
    int m_arrived;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_activity = 0;
            m_duty     = '{0, 0, 0};
            m_tgt      = '{0, 0, 0};
            m_lvl      = 0;
            m_rising   = 1;
            m_pc       = 0;
            m_stp      = 1;
            m_done     = 0;
        end else if (!ena) begin
            m_done = 0;
        end else begin
            m_done = 0;
            if (start) begin
                m_tgt[0] = int'(target_rgb[23:16]);
                m_tgt[1] = int'(target_rgb[15:8]);
                m_tgt[2] = int'(target_rgb[7:0]);
                m_stp    = (step == 0) ? 1 : int'(step);
                m_pc     = 0;
                if (mode == 2'd1) begin
                    m_activity = 1;
                end else if (mode == 2'd2) begin
                    m_activity = 2;
                    m_lvl      = 0;
                    m_rising   = 1;
                end else begin
                    m_activity = 0;
                    m_duty     = m_tgt;
                    m_done     = 1;
                end
            end else if (stop && m_activity != 0) begin
                m_activity = 0;
                m_done     = 1;
            end else if (m_activity != 0) begin
                m_tick = (m_pc == int'(fade_div)) ? 1 : 0;
                m_pc   = m_tick ? 0 : m_pc + 1;
                if (m_activity == 1 && m_tick == 1) begin
                    m_arrived = 1;
                    for (int c = 0; c < 3; c++) begin
                        if (m_duty[c] < m_tgt[c])
                            m_duty[c] += imin(m_stp, m_tgt[c] - m_duty[c]);
                        else if (m_duty[c] > m_tgt[c])
                            m_duty[c] -= imin(m_stp, m_duty[c] - m_tgt[c]);
                        if (m_duty[c] != m_tgt[c]) m_arrived = 0;
                    end
                    if (m_arrived == 1) begin
                        m_activity = 0;
                        m_done     = 1;
                    end
                end else if (m_activity == 2) begin
                    for (int c = 0; c < 3; c++)
                        m_duty[c] = (m_tgt[c] * (m_lvl + 1)) / 256;
                    if (m_tick == 1) begin
                        if (m_rising == 1) begin
                            m_lvl = imin(255, m_lvl + m_stp);
                            if (m_lvl == 255) m_rising = 0;
                        end else begin
                            m_lvl = m_lvl - m_stp;
                            if (m_lvl <= 0) begin
                                m_lvl    = 0;
                                m_rising = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_red",   32'(duty_red),   32'(m_duty[0]));
            check("model_green", 32'(duty_green), 32'(m_duty[1]));
            check("model_blue",  32'(duty_blue),  32'(m_duty[2]));
            check("model_busy",  32'(busy),       32'(m_activity != 0));
            check("model_done",  32'(done),       32'(m_done));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [23:0] tgt, input logic [1:0] md,
                          input logic [3:0] stp, input logic [DIV_W-1:0] div);
        target_rgb = tgt;
        mode       = md;
        step       = stp;
        fade_div   = div;
        start      = 1'b1;
        cycles(1);
        start      = 1'b0;
    endtask

    int n;
    int done_seen;
    logic [7:0] saved_red;

    initial begin
        reset      = 1'b1;
        ena        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        target_rgb = 24'h0;
        mode       = 2'd0;
        step       = 4'd0;
        fade_div   = '0;
        cycles(1);
        cmp_en = 1'b1;
        cycles(2);

        // reset state
        check("rst_red",  32'(duty_red),   32'h00);
        check("rst_grn",  32'(duty_green), 32'h00);
        check("rst_blu",  32'(duty_blue),  32'h00);
        check("rst_busy", 32'(busy),       32'h0);
        check("rst_done", 32'(done),       32'h0);
        reset = 1'b0;
        cycles(1);

        // direct set
        launch(24'h123456, 2'b00, 4'd0, '0);
        check("direct_red",  32'(duty_red),   32'h12);
        check("direct_grn",  32'(duty_green), 32'h34);
        check("direct_blu",  32'(duty_blue),  32'h56);
        check("direct_done", 32'(done),       32'h1);
        check("direct_busy", 32'(busy),       32'h0);
        cycles(1);
        check("direct_done_width", 32'(done), 32'h0);

        // fade up from black
        launch(24'h000000, 2'b11, 4'd0, '0);
        cycles(1);
        launch(24'hFF8000, 2'b01, 4'd4, 16'd2);
        check("fade_busy_rise", 32'(busy), 32'h1);
        cycles(2);
        check("fade_red_pre_tick", 32'(duty_red), 32'h00);
        cycles(1);
        check("fade_red_tick1", 32'(duty_red), 32'h04);
        n = 3;
        while (!done && n < 400) begin
            cycles(1);
            n++;
        end
        check("fade_cycles", 32'(n), 32'd192);
        check("fade_red_end", 32'(duty_red),   32'hFF);
        check("fade_grn_end", 32'(duty_green), 32'h80);
        check("fade_blu_end", 32'(duty_blue),  32'h00);
        check("fade_busy_end", 32'(busy), 32'h0);

        // fade retarget mid-way
        launch(24'h000000, 2'b00, 4'd0, '0);
        launch(24'hFF0000, 2'b01, 4'd4, 16'd0);
        n = 0;
        while (duty_red != 8'h40 && n < 100) begin
            cycles(1);
            n++;
        end
        check("retarget_reach", 32'(n), 32'd16);
        launch(24'h200000, 2'b01, 4'd4, 16'd0);
        check("retarget_nojump", 32'(duty_red), 32'h40);
        cycles(1);
        check("retarget_first", 32'(duty_red), 32'h3C);
        n = 1;
        done_seen = 0;
        while (!done && n < 100) begin
            cycles(1);
            n++;
        end
        check("retarget_cycles", 32'(n), 32'd8);
        check("retarget_red", 32'(duty_red), 32'h20);
        cycles(1);
        check("retarget_done_once", 32'(done), 32'h0);

        // breathe, step 0 behaves as 1
        launch(24'hFF00FF, 2'b10, 4'd0, 16'd0);
        cycles(256);
        check("breathe_peak_red", 32'(duty_red),   32'hFF);
        check("breathe_peak_grn", 32'(duty_green), 32'h00);
        check("breathe_peak_blu", 32'(duty_blue),  32'hFF);
        check("breathe_busy",     32'(busy),       32'h1);
        cycles(255);
        check("breathe_floor_red", 32'(duty_red), 32'h00);
        check("breathe_floor_busy", 32'(busy), 32'h1);
        cycles(5);
        check("breathe_rise_red", 32'(duty_red), 32'h05);
        stop = 1'b1;
        cycles(1);
        stop = 1'b0;
        check("stop_done", 32'(done), 32'h1);
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_red",  32'(duty_red), 32'h05);
        cycles(3);
        check("stop_red_hold", 32'(duty_red), 32'h05);
        check("stop_done_width", 32'(done), 32'h0);

        // enable freeze mid-fade: ticks at E4..E20 take green 0 -> 10
        launch(24'h00C800, 2'b01, 4'd2, 16'd3);
        cycles(20);
        check("ena_pre_grn", 32'(duty_green), 32'd10);
        ena = 1'b0;
        cycles(10);
        check("ena_frozen_grn", 32'(duty_green), 32'd10);
        check("ena_frozen_busy", 32'(busy), 32'h1);
        ena = 1'b1;
        cycles(3);
        check("ena_pc_held", 32'(duty_green), 32'd10);
        cycles(1);
        check("ena_resume_grn", 32'(duty_green), 32'd12);

        // start and stop together: start wins, no done
        target_rgb = 24'h102030;
        mode       = 2'b01;
        step       = 4'd1;
        fade_div   = 16'd0;
        start      = 1'b1;
        stop       = 1'b1;
        cycles(1);
        start = 1'b0;
        stop  = 1'b0;
        check("collide_done", 32'(done), 32'h0);
        check("collide_busy", 32'(busy), 32'h1);

        // reset in the middle of a breathe
        launch(24'h80FF40, 2'b10, 4'd1, 16'd0);
        cycles(128);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("rstmid_red",  32'(duty_red),   32'h00);
        check("rstmid_grn",  32'(duty_green), 32'h00);
        check("rstmid_blu",  32'(duty_blue),  32'h00);
        check("rstmid_busy", 32'(busy),       32'h0);
        check("rstmid_done", 32'(done),       32'h0);
        launch(24'hA1B2C3, 2'b00, 4'd0, '0);
        check("post_rst_red",  32'(duty_red),   32'hA1);
        check("post_rst_blu",  32'(duty_blue),  32'hC3);
        check("post_rst_done", 32'(done),       32'h1);

        // randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 20000; i++) begin
            reset      = ($urandom_range(0, 2999) == 0);
            ena        = ($urandom_range(0, 7) != 0);
            start      = ($urandom_range(0, 59) == 0);
            stop       = ($urandom_range(0, 89) == 0);
            target_rgb = 24'($urandom);
            mode       = 2'($urandom_range(0, 3));
            step       = 4'($urandom_range(0, 15));
            // tick period only changes with an accepted start
            if (start && ena)
                fade_div = 16'($urandom_range(0, 3));
            cycles(1);
        end
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
